noc_resp_depacketizer: RTL and testbench

NOC_RESP_DEPACKETIZER -- requirements
Module: noc_resp_depacketizer

---
 rtl/noc_resp_depacketizer.sv | 226 ++++++++++++++++++++++
 tb/tb_noc_resp_depacketizer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_resp_depacketizer.sv
// NoC response depacketizer: turns response flit packets into AXI B and R
// beats. Two first-word-fall-through output FIFOs, saturating error and
// overflow counters, and a registered flow-control hint to the NoC.
module noc_resp_depacketizer #(
   parameter int DATA_WIDTH    = 128,
   parameter int ID_WIDTH      = 4,
   parameter int BUFFER_DEPTH  = 8,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     noc_clk,
   input  logic                     noc_rst_n,
   input  logic [DATA_WIDTH:0]      noc2axi_data,
   input  logic                     s_is_head,
   input  logic                     s_is_tail,
   output logic                     buffer_busy,
   output logic [ID_WIDTH-1:0]      s_axi_bid,
   output logic [1:0]               s_axi_bresp,
   output logic                     s_axi_bvalid,
   input  logic                     s_axi_bready,
   output logic [ID_WIDTH-1:0]      s_axi_rid,
   output logic [DATA_WIDTH-1:0]    s_axi_rdata,
   output logic [1:0]               s_axi_rresp,
   output logic                     s_axi_rlast,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt,
   output logic [ERR_CNT_WIDTH-1:0] ovf_cnt
);

   localparam int AW   = $clog2(BUFFER_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int CW   = AW + 2;
   localparam int RW   = ID_WIDTH + DATA_WIDTH + 3;
   localparam int BW   = ID_WIDTH + 2;
   localparam int EW1  = ERR_CNT_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, WR_PKT, RD_PKT, DROP} state_t;

   state_t                state, state_nxt;
   logic [ID_WIDTH-1:0]   lat_id, lat_id_nxt;
   logic [1:0]            lat_resp, lat_resp_nxt;
   logic                  pend_valid, pend_valid_nxt;
   logic [DATA_WIDTH-1:0] pend_data, pend_data_nxt;

   logic                  flit_valid;
   logic [DATA_WIDTH-1:0] payload, beat_data;
   logic [3:0]            f_type;
   logic [ID_WIDTH-1:0]   f_src;
   logic [1:0]            f_resp, err_add;

   // Slot 0 carries the beat that closes the open packet, slot 1 the beat of
   // a new empty packet, so a head arriving mid-packet can push twice.
   logic                  r_push0, r_push1, b_push0, b_push1;
   logic [RW-1:0]         r_din0, r_din1, r_dout;
   logic [BW-1:0]         b_din0, b_din1, b_dout;

   logic [RW-1:0]         r_mem [BUFFER_DEPTH];
   logic [BW-1:0]         b_mem [BUFFER_DEPTH];
   logic [AW-1:0]         r_wptr, r_rptr, r_wptr1, b_wptr, b_rptr, b_wptr1;
   logic [CNTW-1:0]       r_cnt, r_cnt_nxt, b_cnt, b_cnt_nxt;
   logic [CW-1:0]         r_avail, b_avail;
   logic                  r_empty, r_pop, r_acc0, r_acc1;
   logic                  b_empty, b_pop, b_acc0, b_acc1;
   logic [1:0]            r_drop, b_drop;
   logic [2:0]            ovf_add;
   logic [EW1-1:0]        err_sum, ovf_sum;

   assign flit_valid = noc2axi_data[DATA_WIDTH];
   assign payload    = noc2axi_data[DATA_WIDTH-1:0];
   assign f_type     = payload[DATA_WIDTH-1 -: 4];
   assign f_src      = payload[DATA_WIDTH-5 -: ID_WIDTH];
   assign f_resp     = payload[1:0];
   assign beat_data  = pend_valid ? pend_data : '0;

   // Packet decode: next FSM state and the FIFO pushes this flit causes
   always_comb begin
      state_nxt      = state;
      lat_id_nxt     = lat_id;
      lat_resp_nxt   = lat_resp;
      pend_valid_nxt = pend_valid;
      pend_data_nxt  = pend_data;
      r_push0 = 1'b0;  r_push1 = 1'b0;  b_push0 = 1'b0;  b_push1 = 1'b0;
      r_din0  = '0;    r_din1  = '0;    b_din0  = '0;    b_din1  = '0;
      err_add = '0;
      if (flit_valid) begin
         if (s_is_head) begin
            if (state != IDLE) begin
               err_add = err_add + 2'd1;
               case (state)
                  WR_PKT: begin
                     b_push0 = 1'b1;
                     b_din0  = {lat_id, 2'b10};
                  end
                  RD_PKT: begin
                     r_push0 = 1'b1;
                     r_din0  = {lat_id, beat_data, 2'b10, 1'b1};
                     if (!pend_valid) err_add = err_add + 2'd1;
                  end
                  default: ;
               endcase
            end
            pend_valid_nxt = 1'b0;
            lat_id_nxt     = f_src;
            lat_resp_nxt   = f_resp;
            case (f_type)
               4'h5:    state_nxt = WR_PKT;
               4'h6:    state_nxt = RD_PKT;
               default: begin
                  state_nxt = DROP;
                  err_add   = err_add + 2'd1;
               end
            endcase
            if (s_is_tail) begin
               if (state_nxt == WR_PKT) begin
                  b_push1 = 1'b1;
                  b_din1  = {f_src, f_resp};
               end else if (state_nxt == RD_PKT) begin
                  r_push1 = 1'b1;
                  r_din1  = {f_src, {DATA_WIDTH{1'b0}}, 2'b10, 1'b1};
                  err_add = err_add + 2'd1;
               end
               state_nxt = IDLE;
            end
         end else if (s_is_tail) begin
            case (state)
               IDLE:   err_add = err_add + 2'd1;
               WR_PKT: begin
                  b_push0 = 1'b1;
                  b_din0  = {lat_id, lat_resp};
               end
               RD_PKT: begin
                  r_push0 = 1'b1;
                  r_din0  = {lat_id, beat_data, pend_valid ? lat_resp : 2'b10, 1'b1};
                  if (!pend_valid) err_add = err_add + 2'd1;
               end
               default: ;
            endcase
            state_nxt      = IDLE;
            pend_valid_nxt = 1'b0;
         end else if (state == RD_PKT) begin
            if (pend_valid) begin
               r_push0 = 1'b1;
               r_din0  = {lat_id, pend_data, lat_resp, 1'b0};
            end
            pend_valid_nxt = 1'b1;
            pend_data_nxt  = payload;
         end
      end
   end

   // FIFO admission: pushes fill free slots in slot order, the rest drop
   always_comb begin
      r_empty   = (r_cnt == '0);
      r_pop     = s_axi_rready & ~r_empty;
      r_avail   = CW'(BUFFER_DEPTH) - CW'(r_cnt) + CW'(r_pop);
      r_acc0    = r_push0 && (r_avail != '0);
      r_acc1    = r_push1 && (r_acc0 ? (r_avail >= CW'(2)) : (r_avail != '0));
      r_wptr1   = r_wptr + AW'(r_acc0);
      r_cnt_nxt = r_cnt + CNTW'(r_acc0) + CNTW'(r_acc1) - CNTW'(r_pop);
      r_drop    = 2'(r_push0 & ~r_acc0) + 2'(r_push1 & ~r_acc1);
      b_empty   = (b_cnt == '0);
      b_pop     = s_axi_bready & ~b_empty;
      b_avail   = CW'(BUFFER_DEPTH) - CW'(b_cnt) + CW'(b_pop);
      b_acc0    = b_push0 && (b_avail != '0);
      b_acc1    = b_push1 && (b_acc0 ? (b_avail >= CW'(2)) : (b_avail != '0));
      b_wptr1   = b_wptr + AW'(b_acc0);
      b_cnt_nxt = b_cnt + CNTW'(b_acc0) + CNTW'(b_acc1) - CNTW'(b_pop);
      b_drop    = 2'(b_push0 & ~b_acc0) + 2'(b_push1 & ~b_acc1);
      ovf_add   = 3'(r_drop) + 3'(b_drop);
      err_sum   = {1'b0, err_cnt} + EW1'(err_add);
      ovf_sum   = {1'b0, ovf_cnt} + EW1'(ovf_add);
   end

   // FIFO storage (no reset needed: outputs are gated by the empty flags)
   always_ff @(posedge noc_clk) begin
      if (r_acc0) r_mem[r_wptr]  <= r_din0;
      if (r_acc1) r_mem[r_wptr1] <= r_din1;
      if (b_acc0) b_mem[b_wptr]  <= b_din0;
      if (b_acc1) b_mem[b_wptr1] <= b_din1;
   end

   // FSM, packet context, FIFO pointers, counters and busy flag
   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         state       <= IDLE;
         lat_id      <= '0;
         lat_resp    <= '0;
         pend_valid  <= 1'b0;
         pend_data   <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_cnt       <= '0;
         b_wptr      <= '0;
         b_rptr      <= '0;
         b_cnt       <= '0;
         err_cnt     <= '0;
         ovf_cnt     <= '0;
         buffer_busy <= 1'b0;
      end else begin
         state       <= state_nxt;
         lat_id      <= lat_id_nxt;
         lat_resp    <= lat_resp_nxt;
         pend_valid  <= pend_valid_nxt;
         pend_data   <= pend_data_nxt;
         r_wptr      <= r_wptr + AW'(r_acc0) + AW'(r_acc1);
         r_rptr      <= r_rptr + AW'(r_pop);
         r_cnt       <= r_cnt_nxt;
         b_wptr      <= b_wptr + AW'(b_acc0) + AW'(b_acc1);
         b_rptr      <= b_rptr + AW'(b_pop);
         b_cnt       <= b_cnt_nxt;
         err_cnt     <= err_sum[ERR_CNT_WIDTH] ? '1 : err_sum[ERR_CNT_WIDTH-1:0];
         ovf_cnt     <= ovf_sum[ERR_CNT_WIDTH] ? '1 : ovf_sum[ERR_CNT_WIDTH-1:0];
         // Built from next-state counts so busy tracks the held count exactly
         buffer_busy <= (r_cnt_nxt >= CNTW'(BUFFER_DEPTH - 2)) ||
                        (b_cnt_nxt >= CNTW'(BUFFER_DEPTH - 1));
      end
   end

   assign r_dout       = r_empty ? '0 : r_mem[r_rptr];
   assign b_dout       = b_empty ? '0 : b_mem[b_rptr];
   assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = r_dout;
   assign {s_axi_bid, s_axi_bresp} = b_dout;
   assign s_axi_rvalid = ~r_empty;
   assign s_axi_bvalid = ~b_empty;

endmodule

// File: tb/tb_noc_resp_depacketizer.sv
// Scoreboard bench for noc_resp_depacketizer: expected B/R beats are queued
// as flits are driven and compared when the DUT hands them out.
module tb_noc_resp_depacketizer;

   localparam int DW = 128;
   localparam int IW = 4;
   localparam int BD = 8;
   localparam int EW = 16;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } rbeat_t;

   logic          noc_clk = 1'b0;
   logic          noc_rst_n;
   logic [DW:0]   noc2axi_data;
   logic          s_is_head, s_is_tail, buffer_busy;
   logic [IW-1:0] s_axi_bid, s_axi_rid;
   logic [1:0]    s_axi_bresp, s_axi_rresp;
   logic          s_axi_bvalid, s_axi_bready, s_axi_rlast, s_axi_rvalid, s_axi_rready;
   logic [DW-1:0] s_axi_rdata;
   logic [EW-1:0] err_cnt, ovf_cnt;

   rbeat_t        r_q[$];
   logic [IW+1:0] b_q[$];
   rbeat_t        r_cur, r_prev;
   logic [IW+1:0] b_cur, b_prev;
   logic          r_held, b_held;
   int            total = 0;
   int            bad = 0;
   int            exp_err = 0;
   int            exp_ovf = 0;

   noc_resp_depacketizer #(
      .DATA_WIDTH(DW), .ID_WIDTH(IW), .BUFFER_DEPTH(BD), .ERR_CNT_WIDTH(EW)
   ) dut (
      .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .noc2axi_data(noc2axi_data),
      .s_is_head(s_is_head), .s_is_tail(s_is_tail), .buffer_busy(buffer_busy),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
      .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready), .err_cnt(err_cnt), .ovf_cnt(ovf_cnt)
   );

   always #5 noc_clk = ~noc_clk;

   assign r_cur = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
   assign b_cur = {s_axi_bid, s_axi_bresp};

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] hdr(input logic [3:0] ty, input logic [IW-1:0] src,
                                          input logic [1:0] rs);
      logic [DW-1:0] p;
      p = '0;
      p[DW-1 -: 4]  = ty;
      p[DW-5 -: IW] = src;
      p[1:0]        = rs;
      return p;
   endfunction

   task automatic exp_r(input logic [IW-1:0] id, input logic [DW-1:0] d,
                        input logic [1:0] rs, input logic l);
      r_q.push_back(rbeat_t'({id, d, rs, l}));
   endtask

   task automatic exp_b(input logic [IW-1:0] id, input logic [1:0] rs);
      b_q.push_back({id, rs});
   endtask

   task automatic send(input logic h, input logic t, input logic [DW-1:0] pl);
      noc2axi_data = {1'b1, pl};
      s_is_head    = h;
      s_is_tail    = t;
      @(posedge noc_clk); #1;
      noc2axi_data = '0;
      s_is_head    = 1'b0;
      s_is_tail    = 1'b0;
   endtask

   task automatic check_cnts(input string tag);
      check({tag, "_err"}, 160'(err_cnt), 160'(exp_err));
      check({tag, "_ovf"}, 160'(ovf_cnt), 160'(exp_ovf));
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((r_q.size() != 0 || b_q.size() != 0) && n < 100) begin
         @(posedge noc_clk);
         n++;
      end
      #1;
      check({tag, "_drain"}, 160'(r_q.size() + b_q.size()), 160'(0));
      repeat (2) @(posedge noc_clk);
      #1;
   endtask

   task automatic do_reset();
      noc_rst_n = 1'b0;
      #2;
      check("rst_valid", {s_axi_bvalid, s_axi_rvalid, s_axi_rlast, buffer_busy}, '0);
      check("rst_bchan", {s_axi_bid, s_axi_bresp}, '0);
      check("rst_rchan", {s_axi_rid, s_axi_rdata, s_axi_rresp}, '0);
      check("rst_cnts", {err_cnt, ovf_cnt}, '0);
      r_q.delete();
      b_q.delete();
      exp_err = 0;
      exp_ovf = 0;
      @(posedge noc_clk); #1;
      noc_rst_n = 1'b1;
      @(posedge noc_clk); #1;
   endtask

   // Scoreboard and hold-stability monitor, sampled mid-cycle
   always @(negedge noc_clk) begin
      if (!noc_rst_n) begin
         r_held = 1'b0;
         b_held = 1'b0;
      end else begin
         if (r_held) check("r_hold", {s_axi_rvalid, r_cur}, {1'b1, r_prev});
         if (b_held) check("b_hold", {s_axi_bvalid, b_cur}, {1'b1, b_prev});
         if (s_axi_rvalid && s_axi_rready) begin
            if (r_q.size() == 0) check("r_unexpected", 160'(s_axi_rvalid), 160'(0));
            else check("r_beat", r_cur, r_q.pop_front());
         end
         if (s_axi_bvalid && s_axi_bready) begin
            if (b_q.size() == 0) check("b_unexpected", 160'(s_axi_bvalid), 160'(0));
            else check("b_beat", 160'(b_cur), 160'(b_q.pop_front()));
         end
         r_held = s_axi_rvalid && !s_axi_rready;
         r_prev = r_cur;
         b_held = s_axi_bvalid && !s_axi_bready;
         b_prev = b_cur;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      noc_rst_n    = 1'b0;
      noc2axi_data = '0;
      s_is_head    = 1'b0;
      s_is_tail    = 1'b0;
      s_axi_rready = 1'b1;
      s_axi_bready = 1'b1;
      r_held       = 1'b0;
      b_held       = 1'b0;
      @(posedge noc_clk); #1;
      do_reset();

      // Write response: one B beat the cycle after the tail edge, no R beat
      send(1'b1, 1'b0, hdr(4'h5, 4'd1, 2'd0));
      send(1'b0, 1'b0, 128'h1234);
      exp_b(4'd1, 2'd0);
      send(1'b0, 1'b1, '0);
      check("b_latency", {s_axi_bvalid, s_axi_bid, s_axi_bresp, s_axi_rvalid},
            {1'b1, 4'd1, 2'd0, 1'b0});
      wait_drain("wr");
      check_cnts("wr");

      // Read burst of three beats, rlast only on the final one
      send(1'b1, 1'b0, hdr(4'h6, 4'd3, 2'd0));
      for (int i = 0; i < 3; i++) begin
         exp_r(4'd3, DW'(10 + i), 2'd0, (i == 2));
         send(1'b0, 1'b0, DW'(10 + i));
      end
      send(1'b0, 1'b1, '0);
      wait_drain("rd");
      check_cnts("rd");

      // Head interrupting a read: close with rresp=2, then a write packet
      send(1'b1, 1'b0, hdr(4'h6, 4'd2, 2'd0));
      send(1'b0, 1'b0, DW'(1));
      exp_r(4'd2, DW'(1), 2'b10, 1'b1);
      exp_err++;
      send(1'b1, 1'b0, hdr(4'h5, 4'd4, 2'd0));
      exp_b(4'd4, 2'd0);
      send(1'b0, 1'b1, '0);
      wait_drain("b2b");
      check_cnts("b2b");

      // Flit with valid=0 is ignored even with head and tail set
      noc2axi_data = {1'b0, hdr(4'h6, 4'd1, 2'd0)};
      s_is_head    = 1'b1;
      s_is_tail    = 1'b1;
      @(posedge noc_clk); #1;
      noc2axi_data = '0;
      s_is_head    = 1'b0;
      s_is_tail    = 1'b0;
      wait_drain("inval");
      check_cnts("inval");

      // Unknown type drops the packet; a head inside DROP opens a new one
      send(1'b1, 1'b0, hdr(4'h9, 4'd2, 2'd0));
      exp_err++;
      send(1'b0, 1'b0, DW'(77));
      send(1'b0, 1'b1, '0);
      send(1'b1, 1'b0, hdr(4'h3, 4'd1, 2'd0));
      exp_err++;
      send(1'b1, 1'b0, hdr(4'h5, 4'd2, 2'd1));
      exp_err++;
      exp_b(4'd2, 2'd1);
      send(1'b0, 1'b1, '0);
      wait_drain("drop");
      check_cnts("drop");

      // Single-flit packets and two pushes from one flit
      exp_r(4'd5, '0, 2'b10, 1'b1);
      exp_err++;
      send(1'b1, 1'b1, hdr(4'h6, 4'd5, 2'd1));
      exp_b(4'd6, 2'd3);
      send(1'b1, 1'b1, hdr(4'h5, 4'd6, 2'd3));
      send(1'b1, 1'b0, hdr(4'h5, 4'd8, 2'd0));
      exp_b(4'd8, 2'b10);
      exp_r(4'd9, '0, 2'b10, 1'b1);
      exp_err += 2;
      send(1'b1, 1'b1, hdr(4'h6, 4'd9, 2'd0));
      send(1'b1, 1'b0, hdr(4'h6, 4'd10, 2'd0));
      send(1'b0, 1'b0, DW'(5));
      exp_r(4'd10, DW'(5), 2'b10, 1'b1);
      exp_r(4'd11, '0, 2'b10, 1'b1);
      exp_err += 2;
      send(1'b1, 1'b1, hdr(4'h6, 4'd11, 2'd0));
      wait_drain("single");
      check_cnts("single");

      // Empty read packet, then a stray tail in IDLE
      do_reset();
      send(1'b1, 1'b0, hdr(4'h6, 4'd7, 2'd0));
      exp_r(4'd7, '0, 2'b10, 1'b1);
      exp_err++;
      send(1'b0, 1'b1, '0);
      send(1'b0, 1'b1, '0);
      exp_err++;
      wait_drain("empty");
      check("empty_err2", 160'(err_cnt), 160'(2));
      check_cnts("empty");

      // Backpressure: R FIFO fills, busy rises at 6, beats 9 and 10 drop
      do_reset();
      s_axi_rready = 1'b0;
      send(1'b1, 1'b0, hdr(4'h6, 4'd1, 2'd0));
      for (int k = 1; k <= 10; k++) begin
         if (k >= 2 && k <= 9) exp_r(4'd1, DW'(k - 1), 2'd0, 1'b0);
         if (k == 10) exp_ovf++;
         send(1'b0, 1'b0, DW'(k));
         check("bp_busy", 160'(buffer_busy), 160'((k - 1) >= 6));
      end
      exp_ovf++;
      send(1'b0, 1'b1, '0);
      check("bp_full_busy", 160'(buffer_busy), 160'(1));
      check_cnts("bp");
      s_axi_rready = 1'b1;
      wait_drain("bp");
      check("bp_idle", {s_axi_rvalid, buffer_busy}, '0);

      // Reset mid-packet discards everything; next packet decodes cleanly
      s_axi_rready = 1'b0;
      send(1'b1, 1'b0, hdr(4'h6, 4'd3, 2'd0));
      send(1'b0, 1'b0, DW'('h11));
      send(1'b0, 1'b0, DW'('h22));
      check("pre_rst_rvalid", 160'(s_axi_rvalid), 160'(1));
      do_reset();
      s_axi_rready = 1'b1;
      send(1'b1, 1'b0, hdr(4'h6, 4'd9, 2'd1));
      send(1'b0, 1'b0, DW'('h33));
      exp_r(4'd9, DW'('h33), 2'd1, 1'b1);
      send(1'b0, 1'b1, '0);
      wait_drain("post_rst");
      check_cnts("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
